fetch_unit: RTL and testbench

- Instruction-fetch responder on the datapath side of the microprogrammed controller.
- Holds the 16-bit program counter (PCH/PCL) and runs a req/ack read cycle to program ROM.
- Latches the returned byte into an instruction register and presents it, with pre-split fields, to the control sequencer through a valid/taken handshake.
- Also serves PC byte reads and loads over the 8-bit internal bus under controller strobes.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Program-ROM read bus between the fetch unit (master) and the ROM (slave).
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              rom_cs;
   logic              rom_rd;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ack;
   logic [DATA_W-1:0] rom_data;

   modport master (
      output rom_cs,
      output rom_rd,
      output rom_addr,
      input  rom_ack,
      input  rom_data
   );

   modport slave (
      input  rom_cs,
      input  rom_rd,
      input  rom_addr,
      output rom_ack,
      output rom_data
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns the PC, runs a req/ack ROM read, holds the
// fetched byte in the instruction register and hands it over via valid/taken.
// ADDR_W must stay 16: the PC is addressed as two 8-bit halves (PCH/PCL).
module fetch_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic              instr_taken,
   input  logic              pch_load,
   input  logic              pcl_load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pch_bus,
   input  logic              pcl_bus,
   output logic [DATA_W-1:0] pc_out,
   fetch_unit_if.master      rom,
   output logic [DATA_W-1:0] instr,
   output logic [2:0]        opcode,
   output logic [1:0]        reg_sel,
   output logic [2:0]        ula_sel,
   output logic              instr_valid,
   output logic              busy,
   output logic              fetch_err
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StValid = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_ld;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              cs_q, cs_d;
   logic              err_q, err_d;
   logic [7:0]        cnt_q, cnt_d;

   // Next-state: FSM, PC loads/increment, ROM strobe and timeout counter
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      cs_d    = cs_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;

      // Bus loads as they would land this cycle; only committed when not busy
      pc_ld = pc_q;
      if (pch_load) pc_ld[ADDR_W-1:DATA_W] = data_in;
      if (pcl_load) pc_ld[DATA_W-1:0]      = data_in;

      case (state_q)
         StIdle: begin
            pc_d = pc_ld;
            if (fetch_req) begin
               // Address includes any load taken on the same edge
               addr_d  = pc_ld;
               cs_d    = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // Ack during issue is ignored; waiting starts next cycle
            cnt_d   = 8'd0;
            state_d = StWait;
         end
         StWait: begin
            if (rom.rom_ack) begin
               instr_d = rom.rom_data;
               pc_d    = pc_q + ADDR_W'(1);
               cs_d    = 1'b0;
               state_d = StValid;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               cs_d    = 1'b0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StValid: begin
            pc_d = pc_ld;
            // A fetch_req seen here is only acted on once back in idle
            if (instr_taken) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= '0;
         cs_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         cs_q    <= cs_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // PC byte onto the internal bus, high byte wins
   always_comb begin
      pc_out = '0;
      if (pch_bus)      pc_out = pc_q[ADDR_W-1:DATA_W];
      else if (pcl_bus) pc_out = pc_q[DATA_W-1:0];
   end

   assign rom.rom_cs   = cs_q;
   assign rom.rom_rd   = cs_q;
   assign rom.rom_addr = addr_q;

   assign instr       = instr_q;
   assign opcode      = instr_q[2:0];
   assign reg_sel     = instr_q[4:3];
   assign ula_sel     = instr_q[7:5];
   assign instr_valid = (state_q == StValid);
   assign busy        = (state_q == StIssue) || (state_q == StWait);
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       fetch_req, instr_taken, pch_load, pcl_load, pch_bus, pcl_bus;
   logic [7:0] data_in, pc_out, instr;
   logic [2:0] opcode, ula_sel;
   logic [1:0] reg_sel;
   logic       instr_valid, busy, fetch_err;

   fetch_unit_if #(.ADDR_W(16), .DATA_W(8)) rom_bus ();

   fetch_unit #(
      .ADDR_W   (16),
      .DATA_W   (8),
      .RESET_PC (16'h0000),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .instr_taken (instr_taken),
      .pch_load    (pch_load),
      .pcl_load    (pcl_load),
      .data_in     (data_in),
      .pch_bus     (pch_bus),
      .pcl_bus     (pcl_bus),
      .pc_out      (pc_out),
      .rom         (rom_bus),
      .instr       (instr),
      .opcode      (opcode),
      .reg_sel     (reg_sel),
      .ula_sel     (ula_sel),
      .instr_valid (instr_valid),
      .busy        (busy),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: PC, IR, pending-instruction flag, age of the outstanding read
   // (-1 none, 0 = issue cycle, k>=1 = k-th waiting cycle), error pulse.
   logic [15:0] m_pc, m_addr;
   logic [7:0]  m_ir;
   bit          m_valid, m_err;
   int          m_age;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_pc    = 16'h0000;
      m_addr  = 16'h0000;
      m_ir    = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_age   = -1;
   endtask

   task automatic m_step();
      bit          n_err = 1'b0;
      logic [15:0] ld;
      ld = m_pc;
      if (pch_load) ld[15:8] = data_in;
      if (pcl_load) ld[7:0]  = data_in;
      if (m_age >= 0) begin
         if (m_age >= 1 && rom_bus.rom_ack) begin
            m_ir    = rom_bus.rom_data;
            m_pc    = m_pc + 16'd1;
            m_valid = 1'b1;
            m_age   = -1;
         end else if (m_age == TIMEOUT) begin
            n_err = 1'b1;
            m_age = -1;
         end else begin
            m_age++;
         end
      end else begin
         m_pc = ld;
         if (m_valid) begin
            if (instr_taken) m_valid = 1'b0;
         end else if (fetch_req) begin
            m_addr = ld;
            m_age  = 0;
         end
      end
      m_err = n_err;
   endtask

   function automatic logic [7:0] exp_pc_out();
      if (pch_bus) return m_pc[15:8];
      if (pcl_bus) return m_pc[7:0];
      return 8'h00;
   endfunction

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("pc_out", pc_out, exp_pc_out());
         chk("rom_cs", rom_bus.rom_cs, m_age >= 0);
         chk("rom_rd", rom_bus.rom_rd, m_age >= 0);
         chk("rom_addr", rom_bus.rom_addr, m_addr);
         chk("instr", instr, m_ir);
         chk("opcode", opcode, m_ir[2:0]);
         chk("reg_sel", reg_sel, m_ir[4:3]);
         chk("ula_sel", ula_sel, m_ir[7:5]);
         chk("instr_valid", instr_valid, m_valid);
         chk("busy", busy, m_age >= 0);
         chk("fetch_err", fetch_err, m_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst) m_reset();
      else     m_step();
      #1;
   endtask

   task automatic go_idle();
      int n = 0;
      fetch_req = 0; pch_load = 0; pcl_load = 0; instr_taken = 1; rom_bus.rom_ack = 1;
      while ((busy || instr_valid) && n < 40) begin
         tick();
         n++;
      end
      chk("go_idle_budget", busy | instr_valid, 1'b0);
      instr_taken = 0; rom_bus.rom_ack = 0;
   endtask

   task automatic read_pc(input string name, input logic [15:0] exp);
      pch_bus = 1; pcl_bus = 0; #1;
      chk({name, "_pch"}, pc_out, exp[15:8]);
      pch_bus = 0; pcl_bus = 1; #1;
      chk({name, "_pcl"}, pc_out, exp[7:0]);
      pcl_bus = 0; #1;
      chk({name, "_none"}, pc_out, 8'h00);
   endtask

   initial begin
      int n;
      int ack_pct;
      rst = 1;
      fetch_req = 0; instr_taken = 0; pch_load = 0; pcl_load = 0;
      pch_bus = 0; pcl_bus = 0; data_in = 8'h00;
      rom_bus.rom_ack = 0; rom_bus.rom_data = 8'h00;
      m_reset();
      #2;
      chk("rst_rom_cs", rom_bus.rom_cs, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_instr", instr, 8'h00);
      chk("rst_addr", rom_bus.rom_addr, 16'h0000);
      @(posedge clk);
      #2 rst = 0;

      // Fetch with ack after two waiting cycles
      fetch_req = 1; tick(); fetch_req = 0;
      tick(); tick(); tick();
      rom_bus.rom_ack = 1; rom_bus.rom_data = 8'hA9; tick(); rom_bus.rom_ack = 0;
      chk("a9_instr", instr, 8'hA9);
      chk("a9_opcode", opcode, 3'd1);
      chk("a9_reg_sel", reg_sel, 2'd1);
      chk("a9_ula_sel", ula_sel, 3'd5);
      chk("a9_valid", instr_valid, 1'b1);
      read_pc("a9_pc", 16'h0001);
      tick(); tick();
      chk("a9_valid_held", instr_valid, 1'b1);
      instr_taken = 1; tick(); instr_taken = 0;
      chk("a9_taken", instr_valid, 1'b0);

      // Minimum latency with ack in the first waiting cycle
      fetch_req = 1; rom_bus.rom_ack = 1; rom_bus.rom_data = 8'h3C; tick(); fetch_req = 0;
      n = 1;
      while (!instr_valid && n < 10) begin
         tick();
         n++;
      end
      chk("latency", 16'(n), 16'd3);
      go_idle();

      // Byte loads then fetch; pcl reads back incremented
      data_in = 8'h12; pch_load = 1; tick(); pch_load = 0;
      data_in = 8'h34; pcl_load = 1; tick(); pcl_load = 0;
      fetch_req = 1; tick(); fetch_req = 0;
      chk("ld_addr", rom_bus.rom_addr, 16'h1234);
      read_pc("ld_pre", 16'h1234);
      rom_bus.rom_ack = 1; tick(); tick();
      read_pc("ld_post", 16'h1235);
      go_idle();

      // Load on the same edge as fetch_req feeds the address
      data_in = 8'h77; pcl_load = 1; fetch_req = 1; tick(); pcl_load = 0; fetch_req = 0;
      chk("ldfetch_addr", rom_bus.rom_addr, 16'h1277);
      go_idle();

      // Both loads together, then wrap FFFF -> 0000
      data_in = 8'hFF; pch_load = 1; pcl_load = 1; tick(); pch_load = 0; pcl_load = 0;
      read_pc("wrap_pre", 16'hFFFF);
      fetch_req = 1; rom_bus.rom_ack = 1; tick(); fetch_req = 0;
      chk("wrap_addr", rom_bus.rom_addr, 16'hFFFF);
      tick(); tick();
      chk("wrap_valid", instr_valid, 1'b1);
      read_pc("wrap_post", 16'h0000);
      go_idle();

      // Timeout: one issue cycle plus TIMEOUT waiting cycles, then one pulse
      data_in = 8'h5A; pch_load = 1; tick(); pch_load = 0;
      data_in = 8'hC3; pcl_load = 1; tick(); pcl_load = 0;
      fetch_req = 1; rom_bus.rom_ack = 0; tick(); fetch_req = 0;
      n = 0;
      while (!fetch_err && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 16'(n), 16'(TIMEOUT + 1));
      chk("timeout_busy", busy, 1'b0);
      tick();
      chk("timeout_once", fetch_err, 1'b0);
      chk("timeout_valid", instr_valid, 1'b0);
      read_pc("timeout_pc", 16'h5AC3);

      // Loads while busy are ignored
      fetch_req = 1; tick(); fetch_req = 0; tick();
      data_in = 8'h00; pch_load = 1; pcl_load = 1; tick(); tick();
      pch_load = 0; pcl_load = 0; rom_bus.rom_ack = 1; rom_bus.rom_data = 8'h66; tick();
      rom_bus.rom_ack = 0;
      chk("busyld_instr", instr, 8'h66);
      read_pc("busyld_pc", 16'h5AC4);
      go_idle();

      // Asynchronous reset in the middle of a wait
      fetch_req = 1; tick(); fetch_req = 0; tick(); tick();
      chk("prerst_busy", busy, 1'b1);
      #2 rst = 1; #1;
      m_reset();
      chk("arst_rom_cs", rom_bus.rom_cs, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_instr", instr, 8'h00);
      chk("arst_addr", rom_bus.rom_addr, 16'h0000);
      read_pc("arst_pc", 16'h0000);
      @(posedge clk);
      #2 rst = 0;

      // Randomized traffic in blocks of varying ROM responsiveness
      for (int blk = 0; blk < 15; blk++) begin
         case (blk % 3)
            0:       ack_pct = 0;
            1:       ack_pct = 30;
            default: ack_pct = 100;
         endcase
         for (int i = 0; i < 200; i++) begin
            fetch_req        = ($urandom_range(0, 99) < 70);
            instr_taken      = ($urandom_range(0, 99) < 40);
            pch_load         = ($urandom_range(0, 99) < 10);
            pcl_load         = ($urandom_range(0, 99) < 10);
            data_in          = 8'($urandom);
            pch_bus          = 1'($urandom_range(0, 1));
            pcl_bus          = 1'($urandom_range(0, 1));
            rom_bus.rom_ack  = (int'($urandom_range(0, 99)) < ack_pct);
            rom_bus.rom_data = 8'($urandom);
            tick();
         end
      end

      go_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
